// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter for two requesters sharing one barrel shifter and a one-entry result buffer
module shifter (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    input  logic [1:0]  i_type,
    output logic [31:0] o_data
);
    logic signed [31:0] w_sra;
    assign w_sra  = $signed(i_data) >>> i_shamt;
    assign o_data = i_type[1] ? w_sra : i_type[0] ? i_data >> i_shamt : i_data << i_shamt;
endmodule

module shift_arbiter #(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_data,
    input  logic [4:0]  i_req0_shamt,
    input  logic [1:0]  i_req0_type,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_data,
    input  logic [4:0]  i_req1_shamt,
    input  logic [1:0]  i_req1_type,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp_data
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t      r_state, w_next;
    logic        r_owner, r_ptr;
    logic [31:0] r_data, w_result;
    logic        w_drain, w_grant, w_accept;
    shifter u_shifter (
        .i_data  (w_grant ? i_req1_data  : i_req0_data),
        .i_shamt (w_grant ? i_req1_shamt : i_req0_shamt),
        .i_type  (w_grant ? i_req1_type  : i_req0_type),
        .o_data  (w_result)
    );
    always_comb begin
        w_drain      = r_state == FULL && (r_owner ? i_rsp1_ready : i_rsp0_ready);
        w_grant      = (i_req0_valid && i_req1_valid) ? r_ptr : i_req1_valid;
        w_accept     = !i_reset && (r_state == EMPTY || w_drain) && (i_req0_valid || i_req1_valid);
        w_next       = w_accept ? FULL : w_drain ? EMPTY : r_state;
        o_req0_ready = w_accept && !w_grant;
        o_req1_ready = w_accept && w_grant;
        o_rsp0_valid = r_state == FULL && !r_owner;
        o_rsp1_valid = r_state == FULL && r_owner;
        o_rsp_data   = r_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= EMPTY;
            r_owner <= 1'b0;
            r_ptr   <= PRIORITY_INIT;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_grant;
                r_ptr   <= !w_grant;
                r_data  <= w_result;
            end
        end
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester round-robin arbiter and sequencer in front of the team's single 32-bit barrel `shifter`. Requesters include the execute-stage shift ops and the load/store byte-lane alignment path. The block owns one `shifter` instance and one registered result buffer. It accepts requests on a valid/ready handshake, grants fairly when both requesters collide, and returns each result, tagged to its owner, one cycle after acceptance. Downstream backpressure is honoured without losing or duplicating results.

## Interface
- `PRIORITY_INIT`, default 0: requester that wins the first collision after reset (0 or 1).

- `i_clk`  in  1: sole clock, rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_req0_valid`  in  1: requester 0 has a request.
- `o_req0_ready`  out  1: requester 0 request accepted this cycle.
- `i_req0_data`  in  32: operand.
- `i_req0_shamt`  in  5: shift amount.
- `i_req0_type`  in  2: 00 SLL, 01 SRL, 1x SRA.
- `i_req1_valid`, `o_req1_ready`, `i_req1_data`, `i_req1_shamt`, `i_req1_type`: same as requester 0, for requester 1.
- `o_rsp0_valid`  out  1: buffered result belongs to requester 0.
- `i_rsp0_ready`  in  1: requester 0 takes the result.
- `o_rsp1_valid`  out  1: buffered result belongs to requester 1.
- `i_rsp1_ready`  in  1: requester 1 takes the result.
- `o_rsp_data`  out  32: shared result bus, meaningful only while a response valid is high.

## Operation
- Clocking and reset: one clock (`i_clk`); reset is synchronous and active-high (`i_reset`).
- State machine:
  - EMPTY: result buffer empty.
  - FULL: buffer holds a result for `owner`.
- Drain: `drain = FULL && i_rsp<owner>_ready`.
- Accept window: `can_accept = EMPTY || drain`.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: requester `ptr` is granted.
  - Neither valid: no grant.
- Ready: `o_reqN_ready = can_accept && grant==N`. At most one ready is high per cycle. Ready may depend on valid; valid must not depend on ready.
- Accept (valid && ready):
  - Granted operands route through `shifter`.
  - Result is captured into `o_rsp_data` and `owner` is set to N.
  - State becomes FULL.
  - `ptr` is set to the other requester, so the last winner has lowest priority.
- `ptr` changes only on accept, never on collisions that are not accepted.
- Drain without accept: state becomes EMPTY; `o_rsp_data` holds its last value.
- Drain with accept in the same cycle: the buffer is overwritten, state stays FULL, and owner may change.
- `o_rspN_valid = FULL && owner==N`. The non-owner ready is ignored.
- Shift rules follow `shifter`:
  - SLL and SRL zero-fill.
  - SRA fills with `data[31]`.
  - shamt 0 passes data unchanged.
  - type 11 behaves as SRA.
- Requester obligation: payload stable while valid && !ready. The block samples payload only at accept.
- Response guarantee: `o_rsp_data` and owner are stable while response valid && !ready.

## Timing
- Latency: accept at edge k makes the response valid from k+1.
- Throughput: 1 result per cycle when the owner holds rsp ready high.
- Fairness: under continuous collision, grants alternate strictly 0,1,0,1… starting at `PRIORITY_INIT`.
- Reset-asserted cycle: both `o_req*_ready` are 0. No accept occurs, even when valid is high.
- State after reset:
  - EMPTY.
  - `o_rsp0_valid`=`o_rsp1_valid`=0.
  - `o_rsp_data`=0.
  - `owner`=0.
  - `ptr`=`PRIORITY_INIT`.
- Reset while FULL: the buffered result is discarded with no response; responses are invalid from the next cycle.
- Backpressure: FULL with owner rsp ready low gives both req readies 0, and no grant or `ptr` change occurs.
- Valid dropped before ready: no accept and no state change. A request withdrawn this way is legal only for bench stress, not in normal use.

## Test plan
- Single SRA: req0 data 0x8000_0001, shamt 4, type 10 → `o_req0_ready` high same cycle; next cycle `o_rsp0_valid`=1, `o_rsp_data`=0xF800_0000.
- Type coverage on req1:
  - SRL of 0x8000_0001, shamt 4 → 0x0800_0000.
  - SLL of 0x0000_0001, shamt 31 → 0x8000_0000.
  - type 11, shamt 0, data 0xDEAD_BEEF → 0xDEAD_BEEF.
- Collision fairness: both valid for 6 cycles, both rsp ready high, `PRIORITY_INIT`=0 → accepts 0,1,0,1,0,1. Back-to-back responses, no idle cycle.
- Backpressure: result for req0 buffered, `i_rsp0_ready` low 3 cycles, req1 valid → `o_rsp0_valid` and data held constant, `o_req1_ready`=0 throughout. Raising `i_rsp0_ready` drains and accepts req1 in the same cycle; req1 response follows next cycle.
- Reset mid-operation: FULL with owner 1, assert `i_reset` one cycle with both req valid → no accept in that cycle; next cycle all response valids 0, `o_rsp_data`=0; first collision then grants `PRIORITY_INIT`.
- Non-owner ready ignored: buffer owned by 0, `i_rsp1_ready`=1, `i_rsp0_ready`=0 → response remains valid, no drain.
